// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts the 1s in a window of 2^WIN_LOG2 valid stochastic bits and reports unipolar count plus bipolar value
// Ports: clk/rst (async, active-high); start begins a window from IDLE; bit_in qualified by bit_valid;
//        busy high while accumulating; done one-cycle pulse with new ones_count (0..N) and bipolar_val (2*ones_count - N)
module sc_stream_decoder #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       busy,
  output logic                       done,
  output logic [WIN_LOG2:0]          ones_count,
  output logic signed [WIN_LOG2+1:0] bipolar_val
);
  localparam int W = WIN_LOG2 + 1;
  localparam logic [W-1:0] N = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [W-1:0] LAST = N - 1'b1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n, acc, acc_n, sum, ones_n;
  logic signed [W:0] bip_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    acc_n = acc;
    ones_n = ones_count;
    bip_n = bipolar_val;
    sum = acc + {{WIN_LOG2{1'b0}}, bit_in};
    case (state)
      IDLE: if (start) begin
        state_n = ACCUM;
        cnt_n = '0;
        acc_n = '0;
      end
      ACCUM: if (bit_valid) begin
        cnt_n = cnt + 1'b1;
        acc_n = sum;
        // the Nth bit is folded into the result directly so the outputs never see a partial sum
        if (cnt == LAST) begin
          state_n = DONE;
          ones_n = sum;
          bip_n = $signed({sum, 1'b0} - {1'b0, N});
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ones_count <= '0;
      bipolar_val <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      acc <= acc_n;
      busy <= state_n == ACCUM;
      done <= state_n == DONE;
      ones_count <= ones_n;
      bipolar_val <= bip_n;
    end
  end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: randomized windows against a counting reference model
module tb_sc_stream_decoder;
  localparam int N = 256;
  logic clk = 1'b0;
  logic rst, start, bit_in, bit_valid, busy, done;
  logic [8:0] ones_count;
  logic signed [9:0] bipolar_val;
  int checks = 0, failures = 0, exp_oc = 0, exp_bp = 0;
  bit bits_q[$];
  sc_stream_decoder #(.WIN_LOG2(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy), .done(done), .ones_count(ones_count), .bipolar_val(bipolar_val)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic s, input logic v, input logic b);
    @(negedge clk);
    start = s;
    bit_valid = v;
    bit_in = b;
  endtask
  task automatic hold_chk(input string tag);
    chk({tag, "_ones"}, ones_count, exp_oc);
    chk({tag, "_bip"}, bipolar_val, exp_bp);
  endtask
  task automatic fill(input int mode);
    int k;
    bits_q.delete();
    for (int i = 0; i < N; i++)
      bits_q.push_back(mode == 0 ? 1'b1 : mode == 2 ? bit'(i % 2 == 0) : mode == 3 ? bit'($urandom_range(0, 1)) : 1'b0);
    k = 0;
    while (mode == 4 && k < 64) begin
      int p = $urandom_range(0, N - 1);
      if (!bits_q[p]) begin
        bits_q[p] = 1'b1;
        k++;
      end
    end
  endtask
  task automatic idle_chk(input int n);
    repeat (n) begin
      drive(1'b0, 1'($urandom), 1'($urandom));
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      hold_chk("idle");
    end
  endtask
  // stall: 0 none, 1 one idle cycle after each bit, 2 random gaps with stray starts
  task automatic feed(input int nbits, input int stall, input logic start_bv, input logic start_in_done);
    int ones = 0;
    for (int i = 0; i < N; i++) ones += int'(bits_q[i]);
    drive(1'b1, start_bv, 1'b1);
    chk("entry_busy", busy, 0);
    chk("entry_done", done, 0);
    hold_chk("entry");
    for (int i = 0; i < nbits; i++) begin
      drive(stall == 2 ? 1'($urandom) : 1'b0, 1'b1, bits_q[i]);
      chk("accum_busy", busy, 1);
      chk("accum_done", done, 0);
      hold_chk("accum");
      if (i != N - 1) begin
        repeat (stall == 1 ? 1 : stall == 2 ? $urandom_range(0, 2) : 0) begin
          drive(stall == 2 ? 1'($urandom) : 1'b0, 1'b0, 1'($urandom));
          chk("stall_busy", busy, 1);
          chk("stall_done", done, 0);
        end
      end
    end
    if (nbits == N) begin
      drive(start_in_done, 1'b0, 1'($urandom));
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      exp_oc = ones;
      exp_bp = 2 * ones - N;
      hold_chk("result");
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    hold_chk("rst");
    rst = 1'b0;
    idle_chk(2);
    fill(0);
    feed(N, 0, 1'b0, 1'b0);
    idle_chk(3);
    fill(1);
    feed(N, 0, 1'b1, 1'b1);
    idle_chk(3);
    fill(2);
    feed(N, 1, 1'b0, 1'b0);
    idle_chk(2);
    fill(0);
    feed(100, 0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_oc = 0;
    exp_bp = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    hold_chk("abort");
    @(negedge clk);
    rst = 1'b0;
    idle_chk(3);
    fill(4);
    feed(N, 2, 1'b0, 1'b0);
    idle_chk(2);
    fill(3);
    feed(N, 2, 1'b1, 1'b0);
    fill(3);
    feed(N, 0, 1'b0, 1'b1);
    idle_chk(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
